rr_decode_arbiter: RTL and testbench



---
 rtl/arb_pkg.sv | 16 +
 rtl/decoder.sv | 13 +
 rtl/rr_decode_arbiter.sv | 117 +++++++++++
 tb/tb_rr_decode_arbiter.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared encodings for the round-robin arbiter: state values, requester count
// and the priority-pointer reset value.
package arb_pkg;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_t;

  localparam int ARB_N     = 4;
  localparam int ARB_IDX_W = 2;

  // Requester 0 is searched first after reset because the search starts at last+1.
  localparam logic [ARB_IDX_W-1:0] ARB_LAST_RST = 2'b11;

endpackage

// File: rtl/decoder.sv
// 2-to-4 decoder with enable.
// D is one-hot at position A while E is high, and all zeros otherwise.
module decoder (
  input  logic [1:0] A,
  input  logic       E,
  output logic [3:0] D
);

  for (genvar gi = 0; gi < 4; gi++) begin : g_dec
    assign D[gi] = E && (A == 2'(gi));
  end

endmodule

// File: rtl/rr_decode_arbiter.sv
// Four-requester round-robin arbiter with a registered grant index and enable,
// decoded to a one-hot grant. Optional hold timeout is enabled with ARB_TIMEOUT_EN.
module rr_decode_arbiter
  import arb_pkg::*;
#(
  parameter int HOLD_MAX = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [ARB_N-1:0]     req,
  output logic [ARB_IDX_W-1:0] gnt_idx,
  output logic                 gnt_en,
  output logic [ARB_N-1:0]     gnt,
  output logic                 expired
);

  // Returns {found, idx}: the first set mask bit in order start+1, +2, +3, start.
  function automatic logic [ARB_IDX_W:0] find_next(input logic [ARB_N-1:0] mask,
                                                   input logic [ARB_IDX_W-1:0] start);
    logic [ARB_IDX_W-1:0] idx;
    find_next = '0;
    for (int i = ARB_N; i >= 1; i--) begin
      idx = start + ARB_IDX_W'(i);
      if (mask[idx]) find_next = {1'b1, idx};
    end
  endfunction

  arb_state_t           state_reg;
  logic [ARB_IDX_W-1:0] gnt_idx_reg;
  logic [ARB_IDX_W-1:0] last_reg;
  logic                 expired_reg;

  logic [ARB_IDX_W:0]   idle_win;
  logic [ARB_IDX_W:0]   release_win;
  logic                 owner_req;

  assign idle_win    = find_next(req, last_reg);
  assign release_win = find_next(req, gnt_idx_reg);
  assign owner_req   = req[gnt_idx_reg];

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

  logic [7:0]           hold_cnt_reg;
  logic [ARB_N-1:0]     other_req;
  logic [ARB_IDX_W:0]   timeout_win;

  // Excluding the owner means a timeout can never re-grant the same requester.
  assign other_req   = req & ~(ARB_N'(1) << gnt_idx_reg);
  assign timeout_win = find_next(other_req, gnt_idx_reg);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ARB_IDLE;
      gnt_idx_reg  <= '0;
      last_reg     <= ARB_LAST_RST;
      expired_reg  <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      hold_cnt_reg <= '0;
`endif
    end else begin
      expired_reg <= 1'b0;
      case (state_reg)
        ARB_IDLE: begin
          if (idle_win[ARB_IDX_W]) begin
            state_reg   <= ARB_GRANT;
            gnt_idx_reg <= idle_win[ARB_IDX_W-1:0];
            last_reg    <= idle_win[ARB_IDX_W-1:0];
`ifdef ARB_TIMEOUT_EN
            hold_cnt_reg <= '0;
`endif
          end
        end
        ARB_GRANT: begin
          if (!owner_req) begin
            if (release_win[ARB_IDX_W]) begin
              gnt_idx_reg <= release_win[ARB_IDX_W-1:0];
              last_reg    <= release_win[ARB_IDX_W-1:0];
`ifdef ARB_TIMEOUT_EN
              hold_cnt_reg <= '0;
`endif
            end else begin
              state_reg <= ARB_IDLE;
            end
          end
`ifdef ARB_TIMEOUT_EN
          else if (hold_cnt_reg == HOLD_LAST && timeout_win[ARB_IDX_W]) begin
            gnt_idx_reg  <= timeout_win[ARB_IDX_W-1:0];
            last_reg     <= timeout_win[ARB_IDX_W-1:0];
            hold_cnt_reg <= '0;
            expired_reg  <= 1'b1;
          end else if (hold_cnt_reg != HOLD_LAST) begin
            hold_cnt_reg <= hold_cnt_reg + 8'd1;
          end
`endif
        end
        default: state_reg <= ARB_IDLE;
      endcase
    end
  end

  assign gnt_idx = gnt_idx_reg;
  assign gnt_en  = (state_reg == ARB_GRANT);
`ifdef ARB_TIMEOUT_EN
  assign expired = expired_reg;
`else
  assign expired = 1'b0;
`endif

  decoder u_dec (
    .A (gnt_idx),
    .E (gnt_en),
    .D (gnt)
  );

endmodule

// File: tb/tb_rr_decode_arbiter.sv
// Directed bench for rr_decode_arbiter: reset, rotation, wrap/skip, release to idle
// and hold timeout (behaviour depends on whether ARB_TIMEOUT_EN is defined).
module tb_rr_decode_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [1:0] gnt_idx;
  logic       gnt_en;
  logic [3:0] gnt;
  logic       expired;

  int n_checks = 0;
  int n_fail   = 0;

  rr_decode_arbiter #(.HOLD_MAX(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .gnt_idx (gnt_idx),
    .gnt_en  (gnt_en),
    .gnt     (gnt),
    .expired (expired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Advance one clock and sample 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
    $display("t=%0t req=%b gnt=%b idx=%0d en=%b exp=%b", $time, req, gnt, gnt_idx, gnt_en, expired);
    check("onehot", {31'b0, ($countones(gnt) <= 1)}, 32'd1);
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 4'b0000;
    #3;
    check("rst_gnt", {28'b0, gnt}, 32'h0);
    check("rst_en", {31'b0, gnt_en}, 32'h0);
    check("rst_idx", {30'b0, gnt_idx}, 32'h0);
    check("rst_exp", {31'b0, expired}, 32'h0);
    tick();
    tick();
    rst_n = 1'b1;

    // First grant after reset goes to requester 0.
    req = 4'b1111;
    tick();
    check("first_gnt", {28'b0, gnt}, 32'h1);

    // Rotation: each owner keeps the grant for 3 cycles, then drops req for one cycle.
    for (int k = 0; k < 4; k++) begin
      for (int c = 0; c < 2; c++) begin
        tick();
        check("rot_hold", {28'b0, gnt}, 32'(4'b0001 << k));
      end
      req = 4'b1111 & ~(4'b0001 << k);
      tick();
      check("rot_next", {28'b0, gnt}, 32'(4'b0001 << ((k + 1) % 4)));
      req = 4'b1111;
    end
    check("rot_idx", {30'b0, gnt_idx}, 32'h0);

    // Wrap and skip: owner 0 releases to 3, then 3 releases straight to 2.
    req = 4'b1000;
    tick();
    check("skip_to3", {28'b0, gnt}, 32'h8);
    req = 4'b0100;
    tick();
    check("wrap_gnt", {28'b0, gnt}, 32'h4);
    check("wrap_en", {31'b0, gnt_en}, 32'h1);
    req = 4'b0000;
    tick();
    check("idle_gnt", {28'b0, gnt}, 32'h0);
    check("idle_idx", {30'b0, gnt_idx}, 32'h2);

    // Release to idle: req[1] alone for 4 cycles.
    req = 4'b0010;
    for (int c = 0; c < 4; c++) begin
      tick();
      check("r1_gnt", {28'b0, gnt}, 32'h2);
    end
    req = 4'b0000;
    tick();
    check("r1_off_gnt", {28'b0, gnt}, 32'h0);
    check("r1_off_en", {31'b0, gnt_en}, 32'h0);
    check("r1_off_idx", {30'b0, gnt_idx}, 32'h1);
    tick();
    check("r1_keep_idx", {30'b0, gnt_idx}, 32'h1);

    // Timeout: req=0011 held; search from last=1 picks requester 0.
    req = 4'b0011;
`ifdef ARB_TIMEOUT_EN
    for (int c = 0; c < 4; c++) begin
      tick();
      check("to_hold", {28'b0, gnt}, 32'h1);
      check("to_hold_exp", {31'b0, expired}, 32'h0);
    end
    tick();
    check("to_hand_gnt", {28'b0, gnt}, 32'h2);
    check("to_hand_exp", {31'b0, expired}, 32'h1);
    tick();
    check("to_after_gnt", {28'b0, gnt}, 32'h2);
    check("to_after_exp", {31'b0, expired}, 32'h0);
    // Only requester 0 left: it takes over and keeps the grant.
    req = 4'b0001;
    for (int c = 0; c < 20; c++) begin
      tick();
      check("to_solo_gnt", {28'b0, gnt}, 32'h1);
      check("to_solo_exp", {31'b0, expired}, 32'h0);
    end
`else
    for (int c = 0; c < 50; c++) begin
      tick();
      check("noto_gnt", {28'b0, gnt}, 32'h1);
      check("noto_exp", {31'b0, expired}, 32'h0);
    end
`endif

    // Asynchronous reset while requester 0 holds the grant.
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_gnt", {28'b0, gnt}, 32'h0);
    check("arst_en", {31'b0, gnt_en}, 32'h0);
    check("arst_exp", {31'b0, expired}, 32'h0);
    check("arst_idx", {30'b0, gnt_idx}, 32'h0);
    req = 4'b1111;
    tick();
    check("arst_held", {28'b0, gnt}, 32'h0);
    rst_n = 1'b1;
    tick();
    check("arst_first", {28'b0, gnt}, 32'h1);
    check("arst_first_idx", {30'b0, gnt_idx}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
